// File: rtl/user_cap_upd_reg_pkg.sv
// Shared definitions for the JTAG user capture/update register: width helper,
// synchroniser depth default and the sticky status flag bundle.
package user_cap_upd_reg_pkg;

    localparam int SYNC_STAGES_DEF = 2;

    typedef struct packed {
        logic len_err;
        logic drop;
    } xfer_flags_t;

    // Smallest r with 2**r >= value; elaboration-time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/user_cap_upd_reg_sync_bit.sv
// Multi-flop level synchroniser for a single control bit, cleared by asynchronous RST.
module sync_bit
    import user_cap_upd_reg_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Synchroniser chain; the oldest stage drives the output.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            chain_r <= '0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/user_cap_upd_reg.sv
// JTAG user data register: parallel capture of a selected status channel, serial
// shift, and length-checked update delivered to the fabric clock by toggle handshake.
module user_cap_upd_reg
    import user_cap_upd_reg_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int CHW        = (NCH > 1) ? clog2(NCH) : 1
) (
    input  logic                 DRCK,
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SEL,
    input  logic                 FSH,
    input  logic                 FCAP,
    input  logic                 FUPD,
    input  logic                 CAPTURE,
    input  logic                 SHIFT,
    input  logic                 UPDATE,
    input  logic                 TDI,
    input  logic [CHW-1:0]       CHSEL,
    input  logic [NCH*WIDTH-1:0] BUS,
    output logic                 TDO,
    output logic [WIDTH-1:0]     DOUT,
    output logic                 DOUT_VLD,
    output logic                 LEN_ERR,
    output logic                 DROP
);

    localparam int              CNTW     = clog2(WIDTH + 2);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] CNT_SAT  = CNTW'(WIDTH + 1);

    logic             sh_en_s;
    logic             cap_en_s;
    logic             upd_en_s;
    logic             cnt_clr_s;
    logic [WIDTH-1:0] cap_word_s;
    logic [WIDTH-1:0] q_r;
    logic [CNTW-1:0]  cnt_r;
    logic [WIDTH-1:0] upd_reg_r;
    logic             tog_r;
    logic             ack_s;
    xfer_flags_t      flags_r;
    logic             tog_sync_s;
    logic             xfer_edge_s;
    logic             ack_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;

    assign sh_en_s   = SEL & SHIFT & (FSH | FCAP | FUPD);
    assign cap_en_s  = SEL & FCAP & CAPTURE;
    assign upd_en_s  = SEL & FUPD & UPDATE;
    assign cnt_clr_s = SEL & CAPTURE;
    assign TDO       = sh_en_s & q_r[0];

    // Channel mux; a channel number beyond NCH captures zero.
    always_comb begin
        cap_word_s = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(CHSEL) == k) begin
                cap_word_s = BUS[k*WIDTH +: WIDTH];
            end else begin
                cap_word_s = cap_word_s;
            end
        end
    end

    // Shift register: capture has priority over shift.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            q_r <= '0;
        end else if (cap_en_s) begin
            q_r <= cap_word_s;
        end else if (sh_en_s) begin
            q_r <= {TDI, q_r[WIDTH-1:1]};
        end else begin
            q_r <= q_r;
        end
    end

    // Shift length counter, saturating one past WIDTH so overlong scans stay invalid.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            cnt_r <= '0;
        end else if (cnt_clr_s) begin
            cnt_r <= '0;
        end else if (sh_en_s && (cnt_r != CNT_SAT)) begin
            cnt_r <= cnt_r + CNTW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Update acceptance; upd_reg_r is frozen while tog_r and ack_s disagree.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            upd_reg_r <= '0;
            tog_r     <= 1'b0;
            flags_r   <= '0;
        end else if (upd_en_s) begin
            if (cnt_r != CNT_FULL) begin
                flags_r.len_err <= 1'b1;
            end else if (tog_r != ack_s) begin
                flags_r.drop <= 1'b1;
            end else begin
                upd_reg_r       <= q_r;
                tog_r           <= ~tog_r;
                flags_r.len_err <= 1'b0;
            end
        end else begin
            upd_reg_r <= upd_reg_r;
            tog_r     <= tog_r;
            flags_r   <= flags_r;
        end
    end

    sync_bit #(.STAGES(SYNC_STAGES)) u_tog_sync (
        .clk (CLK),
        .RST (RST),
        .d   (tog_r),
        .q   (tog_sync_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk (DRCK),
        .RST (RST),
        .d   (ack_r),
        .q   (ack_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_len_sync (
        .clk (CLK),
        .RST (RST),
        .d   (flags_r.len_err),
        .q   (LEN_ERR)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_drop_sync (
        .clk (CLK),
        .RST (RST),
        .d   (flags_r.drop),
        .q   (DROP)
    );

    // ack_r doubles as the edge-detect flop: it follows the synced toggle once consumed.
    assign xfer_edge_s = tog_sync_s ^ ack_r;

    // Fabric-side capture of the transferred word with a one-cycle valid pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            ack_r      <= 1'b0;
        end else if (xfer_edge_s) begin
            dout_r     <= upd_reg_r;
            dout_vld_r <= 1'b1;
            ack_r      <= tog_sync_s;
        end else begin
            dout_r     <= dout_r;
            dout_vld_r <= 1'b0;
            ack_r      <= ack_r;
        end
    end

    assign DOUT     = dout_r;
    assign DOUT_VLD = dout_vld_r;

endmodule

// File: tb/tb_user_cap_upd_reg.sv
// Randomised bench for user_cap_upd_reg against a queue-based model of the scan chain
// and a rule-level model of update acceptance.
`timescale 1ns/1ps
module tb_user_cap_upd_reg;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           DRCK = 1'b0;
    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           SEL = 1'b0;
    logic           FSH = 1'b0;
    logic           FCAP = 1'b0;
    logic           FUPD = 1'b0;
    logic           CAPTURE = 1'b0;
    logic           SHIFT = 1'b0;
    logic           UPDATE = 1'b0;
    logic           TDI = 1'b0;
    logic [CHW-1:0] CHSEL = '0;
    logic [NCH*W-1:0] BUS = '0;
    logic           TDO;
    logic [W-1:0]   DOUT;
    logic           DOUT_VLD;
    logic           LEN_ERR;
    logic           DROP;

    int clk_half = 7;
    int n_checks = 0;
    int n_pass   = 0;
    int vld_seen = 0;

    // Reference model state
    bit         qm[$];
    int         m_len;
    logic [W-1:0] m_dout;
    logic       m_len_err;
    logic       m_drop;
    bit         m_busy;

    user_cap_upd_reg #(.WIDTH(W), .NCH(NCH), .SYNC_STAGES(2)) dut (
        .DRCK(DRCK), .CLK(CLK), .RST(RST), .SEL(SEL), .FSH(FSH), .FCAP(FCAP),
        .FUPD(FUPD), .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE), .TDI(TDI),
        .CHSEL(CHSEL), .BUS(BUS), .TDO(TDO), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
        .LEN_ERR(LEN_ERR), .DROP(DROP)
    );

    always #10 DRCK = ~DRCK;
    always #(clk_half) CLK = ~CLK;

    always @(negedge CLK) begin
        if (DOUT_VLD === 1'b1) vld_seen <= vld_seen + 1;
    end

    function automatic logic [W-1:0] qm_word();
        logic [W-1:0] w;
        for (int i = 0; i < W; i++) w[i] = qm[i];
        return w;
    endfunction

    task automatic model_reset();
        qm = {};
        for (int i = 0; i < W; i++) qm.push_back(1'b0);
        m_len = 0; m_dout = '0; m_len_err = 1'b0; m_drop = 1'b0; m_busy = 1'b0;
    endtask

    task automatic do_capture(input logic [CHW-1:0] ch);
        @(negedge DRCK); SEL = 1'b1; CHSEL = ch; CAPTURE = 1'b1;
        @(negedge DRCK); CAPTURE = 1'b0;
        m_len = 0;
        if (FCAP) begin
            qm = {};
            for (int i = 0; i < W; i++) qm.push_back(BUS[int'(ch)*W + i]);
        end
    endtask

    task automatic shift_word(input logic [W-1:0] data, input int n,
                              output logic [W-1:0] got, output logic [W-1:0] exp_out);
        got = '0; exp_out = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge DRCK); SHIFT = 1'b1; TDI = data[i % W];
            #1;
            if (i < W) begin
                got[i] = TDO;
                exp_out[i] = qm[0];
            end
            void'(qm.pop_front());
            qm.push_back(data[i % W]);
            m_len++;
        end
        @(negedge DRCK); SHIFT = 1'b0;
    endtask

    task automatic do_update(output bit accepted);
        @(negedge DRCK); UPDATE = 1'b1;
        @(negedge DRCK); UPDATE = 1'b0;
        accepted = 1'b0;
        if (FUPD) begin
            if (m_len != W) m_len_err = 1'b1;
            else if (m_busy) m_drop = 1'b1;
            else begin
                m_dout = qm_word(); m_len_err = 1'b0; m_busy = 1'b1; accepted = 1'b1;
            end
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge CLK);
        repeat (4) @(negedge DRCK);
        m_busy = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        model_reset();
        repeat (3) @(negedge DRCK);
        n_checks++; if (TDO !== 1'b0) $display("FAIL reset_tdo: got %b expected 0", TDO); else n_pass++;
        n_checks++; if (DOUT !== 8'h00) $display("FAIL reset_dout: got %h expected 00", DOUT); else n_pass++;
        n_checks++; if (DOUT_VLD !== 1'b0) $display("FAIL reset_vld: got %b expected 0", DOUT_VLD); else n_pass++;
        n_checks++; if ({LEN_ERR, DROP} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {LEN_ERR, DROP}); else n_pass++;
        RST = 1'b0;
        repeat (2) @(negedge DRCK);
    endtask

    task automatic test_capture();
        logic [W-1:0] got, exp_out;
        logic [CHW-1:0] ch;
        FSH = 1'b0; FCAP = 1'b1; FUPD = 1'b0;
        BUS = {8'h44, 8'h33, 8'h22, 8'h11};
        do_capture(2'd2);
        shift_word(8'($urandom), W, got, exp_out);
        n_checks++; if (got !== 8'h33) $display("FAIL capture_ch2: got %h expected 33", got); else n_pass++;
        do_capture(2'd3);
        shift_word(8'($urandom), W, got, exp_out);
        n_checks++; if (got !== 8'h44) $display("FAIL capture_ch3: got %h expected 44", got); else n_pass++;
        for (int t = 0; t < 6; t++) begin
            BUS = {$urandom};
            ch = CHW'($urandom_range(0, NCH - 1));
            do_capture(ch);
            shift_word(8'($urandom), W, got, exp_out);
            n_checks++; if (got !== exp_out) $display("FAIL capture_rand ch=%0d: got %h expected %h", ch, got, exp_out); else n_pass++;
        end
    endtask

    task automatic test_update();
        logic [W-1:0] w, got, exp_out;
        int v0;
        bit acc;
        FSH = 1'b0; FCAP = 1'b0; FUPD = 1'b1;
        for (int t = 0; t < 4; t++) begin
            w = (t == 0) ? 8'hA5 : 8'($urandom);
            do_capture(2'd0);
            shift_word(w, W, got, exp_out);
            v0 = vld_seen;
            do_update(acc);
            repeat (5) @(negedge CLK);
            n_checks++; if ((vld_seen - v0) !== (acc ? 1 : 0)) $display("FAIL update_pulse: got %0d expected %0d", vld_seen - v0, acc ? 1 : 0); else n_pass++;
            n_checks++; if (DOUT !== w) $display("FAIL update_dout: got %h expected %h", DOUT, w); else n_pass++;
            n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL update_len_err: got %b expected 0", LEN_ERR); else n_pass++;
            settle();
            n_checks++; if ((vld_seen - v0) !== 1) $display("FAIL update_single_pulse: got %0d expected 1", vld_seen - v0); else n_pass++;
        end
    endtask

    task automatic test_bad_length();
        logic [W-1:0] got, exp_out, w;
        int v0, n;
        bit acc;
        FSH = 1'b0; FCAP = 1'b0; FUPD = 1'b1;
        for (int t = 0; t < 3; t++) begin
            n = (t == 0) ? 7 : (($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(9, 12));
            do_capture(2'd1);
            shift_word(8'($urandom), n, got, exp_out);
            v0 = vld_seen;
            do_update(acc);
            repeat (6) @(negedge CLK);
            n_checks++; if ((vld_seen - v0) !== 0) $display("FAIL badlen_pulse n=%0d: got %0d expected 0", n, vld_seen - v0); else n_pass++;
            n_checks++; if (DOUT !== m_dout) $display("FAIL badlen_dout n=%0d: got %h expected %h", n, DOUT, m_dout); else n_pass++;
            n_checks++; if (LEN_ERR !== m_len_err) $display("FAIL badlen_flag n=%0d: got %b expected %b", n, LEN_ERR, m_len_err); else n_pass++;
            settle();
        end
        w = 8'($urandom);
        do_capture(2'd1);
        shift_word(w, W, got, exp_out);
        v0 = vld_seen;
        do_update(acc);
        settle();
        n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL badlen_clear: got %b expected 0", LEN_ERR); else n_pass++;
        n_checks++; if (DOUT !== w) $display("FAIL badlen_recover_dout: got %h expected %h", DOUT, w); else n_pass++;
        n_checks++; if ((vld_seen - v0) !== 1) $display("FAIL badlen_recover_pulse: got %0d expected 1", vld_seen - v0); else n_pass++;
    endtask

    task automatic test_shift_only();
        logic [W-1:0] got, exp_out;
        int v0;
        bit acc;
        FSH = 1'b1; FCAP = 1'b0; FUPD = 1'b0;
        do_capture(2'd1);
        shift_word(8'h3C, W, got, exp_out);
        n_checks++; if (got !== exp_out) $display("FAIL shonly_echo: got %h expected %h", got, exp_out); else n_pass++;
        v0 = vld_seen;
        do_update(acc);
        settle();
        n_checks++; if ((vld_seen - v0) !== 0) $display("FAIL shonly_upd_pulse: got %0d expected 0", vld_seen - v0); else n_pass++;
        n_checks++; if (DOUT !== m_dout) $display("FAIL shonly_dout: got %h expected %h", DOUT, m_dout); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge DRCK); SEL = 1'b0; SHIFT = 1'b1; TDI = 1'($urandom);
            #1;
            n_checks++; if (TDO !== 1'b0) $display("FAIL shonly_sel0_tdo: got %b expected 0", TDO); else n_pass++;
        end
        @(negedge DRCK); SHIFT = 1'b0; SEL = 1'b1;
        shift_word(8'($urandom), W, got, exp_out);
        n_checks++; if (got !== 8'h3C) $display("FAIL shonly_hold: got %h expected 3c", got); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [W-1:0] got, exp_out;
        int v0;
        bit acc1, acc2;
        clk_half = 100;
        repeat (3) @(negedge CLK);
        FSH = 1'b0; FCAP = 1'b0; FUPD = 1'b1;
        v0 = vld_seen;
        do_capture(2'd0);
        shift_word(8'h01, W, got, exp_out);
        do_update(acc1);
        do_capture(2'd0);
        shift_word(8'h02, W, got, exp_out);
        do_update(acc2);
        repeat (10) @(negedge CLK);
        n_checks++; if ((vld_seen - v0) !== 1) $display("FAIL overrun_pulses: got %0d expected 1", vld_seen - v0); else n_pass++;
        n_checks++; if (DOUT !== 8'h01) $display("FAIL overrun_dout: got %h expected 01", DOUT); else n_pass++;
        n_checks++; if (DROP !== m_drop) $display("FAIL overrun_drop: got %b expected %b", DROP, m_drop); else n_pass++;
        n_checks++; if (LEN_ERR !== 1'b0) $display("FAIL overrun_len_err: got %b expected 0", LEN_ERR); else n_pass++;
        clk_half = 7;
        settle();
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] got, exp_out, w;
        int v0;
        bit acc;
        FSH = 1'b0; FCAP = 1'b0; FUPD = 1'b1;
        do_capture(2'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge DRCK); SHIFT = 1'b1; TDI = 1'b1;
        end
        RST = 1'b1;
        model_reset();
        #1;
        n_checks++; if (TDO !== 1'b0) $display("FAIL rst_shift_tdo: got %b expected 0", TDO); else n_pass++;
        n_checks++; if (DOUT !== 8'h00) $display("FAIL rst_shift_dout: got %h expected 00", DOUT); else n_pass++;
        n_checks++; if ({DOUT_VLD, LEN_ERR, DROP} !== 3'b000) $display("FAIL rst_shift_flags: got %b expected 000", {DOUT_VLD, LEN_ERR, DROP}); else n_pass++;
        @(negedge DRCK); SHIFT = 1'b0; RST = 1'b0;
        do_capture(2'd0);
        shift_word(8'($urandom), W, got, exp_out);
        v0 = vld_seen;
        do_update(acc);
        RST = 1'b1;
        model_reset();
        repeat (3) @(negedge DRCK);
        RST = 1'b0;
        settle();
        n_checks++; if ((vld_seen - v0) !== 0) $display("FAIL rst_hs_pulse: got %0d expected 0", vld_seen - v0); else n_pass++;
        n_checks++; if (DOUT !== 8'h00) $display("FAIL rst_hs_dout: got %h expected 00", DOUT); else n_pass++;
        w = 8'($urandom);
        do_capture(2'd0);
        shift_word(w, W, got, exp_out);
        v0 = vld_seen;
        do_update(acc);
        settle();
        n_checks++; if ((vld_seen - v0) !== 1) $display("FAIL rst_after_pulse: got %0d expected 1", vld_seen - v0); else n_pass++;
        n_checks++; if (DOUT !== w) $display("FAIL rst_after_dout: got %h expected %h", DOUT, w); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_update();
        test_bad_length();
        test_shift_only();
        test_overrun();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
